// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared select codes, shadow-stage record and match helpers
package hazard_ctrl_pkg;
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_t;

    // register 0 is hard-wired, so it never matches a producer
    function automatic logic hit(stage_t s, logic [4:0] r);
        return s.valid && s.dst == r && r != 5'd0;
    endfunction

    // producer whose result is not ready before the consumer needs it
    function automatic logic late(stage_t s, logic [4:0] r, logic [1:0] t);
        return hit(s, r) && s.tnew > t;
    endfunction

    // nearest ready producer wins: M over W
    function automatic logic [1:0] fwd_sel(stage_t m, stage_t w, logic [4:0] r);
        return (hit(m, r) && m.tnew == 2'd0) ? FWD_M : hit(w, r) ? FWD_W : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// md_busy_ctr: HI/LO unit occupancy counter
//  clk, rst_n      clock, async active-low reset
//  load_i          load load_val_i this cycle
//  load_val_i      occupancy in cycles
//  busy_o          counter non-zero
module md_busy_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         busy_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign busy_o = cnt_q != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard stall and operand-forwarding control for the 5-stage pipeline
//  clk, rst_n                  clock, async active-low reset
//  rs_d, rt_d, use_*, tuse_*   D-stage sources and when they are consumed
//  dst_d, tnew_d               D-stage destination and result latency
//  md_start_d, md_div_d        D instr is mult/div (div when md_div_d)
//  md_use_d                    D instr accesses HI/LO
//  stall                       freeze F/D, bubble into E
//  fwd_*                       forwarding-mux selects (0 RF, 1 M, 2 W)
//  md_busy                     HI/LO unit occupied
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       use_rs_d,
    input  logic       use_rt_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] tnew_d,
    input  logic       md_start_d,
    input  logic       md_div_d,
    input  logic       md_use_d,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic [1:0] fwd_rt_m,
    output logic       md_busy
);
    localparam int MW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

    stage_t e_q, m_q, w_q, e_d, m_d, w_d;
    logic   e_md_q, e_div_q;

    always_comb begin
        e_d = stall ? '0 : '{1'b1, dst_d, tnew_d, rs_d, rt_d};
        m_d = e_q;
        m_d.tnew = e_q.tnew == 2'd0 ? 2'd0 : e_q.tnew - 2'd1;
        w_d = m_q;
        w_d.tnew = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            e_md_q  <= 1'b0;
            e_div_q <= 1'b0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            e_md_q  <= md_start_d & ~stall;
            e_div_q <= md_div_d;
        end

    // the unit is claimed while the mult/div sits in E and counts down afterwards
    md_busy_ctr #(.W(MW)) u_md (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (e_md_q),
        .load_val_i (e_div_q ? MW'(DIV_CYCLES) : MW'(MULT_CYCLES)),
        .busy_o     (md_busy)
    );

    assign stall = (use_rs_d & (late(e_q, rs_d, tuse_rs_d) | late(m_q, rs_d, tuse_rs_d)))
                 | (use_rt_d & (late(e_q, rt_d, tuse_rt_d) | late(m_q, rt_d, tuse_rt_d)))
                 | ((md_start_d | md_use_d) & (md_busy | e_md_q));

    assign fwd_rs_d = fwd_sel(m_q, w_q, rs_d);
    assign fwd_rt_d = fwd_sel(m_q, w_q, rt_d);
    assign fwd_rs_e = fwd_sel(m_q, w_q, e_q.rs);
    assign fwd_rt_e = fwd_sel(m_q, w_q, e_q.rt);
    assign fwd_rt_m = hit(w_q, m_q.rt) ? FWD_W : FWD_RF;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, dst_d;
    logic       use_rs_d, use_rt_d, md_start_d, md_div_d, md_use_d;
    logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
    int         tests = 0;
    int         fails = 0;
    int         sc, bc;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
        .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
        .dst_d(dst_d), .tnew_d(tnew_d), .md_start_d(md_start_d),
        .md_div_d(md_div_d), .md_use_d(md_use_d), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] dst, input logic [1:0] tn, input logic mds,
                         input logic mdd, input logic mdu);
        rs_d = rs; rt_d = rt; use_rs_d = urs; use_rt_d = urt;
        tuse_rs_d = trs; tuse_rt_d = trt; dst_d = dst; tnew_d = tn;
        md_start_d = mds; md_div_d = mdd; md_use_d = mdu;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) cyc();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_fwd_rs_d"}, fwd_rs_d, 0);
        chk({tag, "_fwd_rt_d"}, fwd_rt_d, 0);
        chk({tag, "_fwd_rs_e"}, fwd_rs_e, 0);
        chk({tag, "_fwd_rt_e"}, fwd_rt_e, 0);
        chk({tag, "_fwd_rt_m"}, fwd_rt_m, 0);
        chk({tag, "_md_busy"}, md_busy, 0);
    endtask

    initial begin
        nop();
        rst_n = 1'b0;
        #3;
        chk_all_zero("reset");
        cyc();
        rst_n = 1'b1;

        // lw $2 (tnew 2) ; add $3,$2,$2 (tuse 1): one stall, then add in E meets lw in W
        set_d(0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0);
        #1 chk("t1_lw_nostall", stall, 0);
        cyc();
        set_d(2, 2, 1, 1, 1, 1, 3, 1, 0, 0, 0);
        #1 chk("t1_stall", stall, 1);
        cyc();
        #1 chk("t1_release", stall, 0);
        cyc();
        nop();
        #1 chk("t1_fwd_rs_e", fwd_rs_e, 2);
        chk("t1_fwd_rt_e", fwd_rt_e, 2);
        flush();

        // addu $4 (tnew 1) ; beq $4,$0 (tuse 0): one stall, then M forward in D
        set_d(0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
        cyc();
        set_d(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t2_stall", stall, 1);
        chk("t2_fwd_rs_d_stalled", fwd_rs_d, 0);
        cyc();
        #1 chk("t2_release", stall, 0);
        chk("t2_fwd_rs_d", fwd_rs_d, 1);
        chk("t2_fwd_rt_d_r0", fwd_rt_d, 0);
        flush();

        // addu $5 ; nop ; sw $5 (tuse 2): no stall, W forward in E
        set_d(0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        cyc();
        nop();
        cyc();
        set_d(1, 5, 1, 1, 1, 2, 0, 0, 0, 0, 0);
        #1 chk("t3_nostall", stall, 0);
        chk("t3_fwd_rt_d", fwd_rt_d, 1);
        cyc();
        nop();
        #1 chk("t3_fwd_rt_e", fwd_rt_e, 2);
        chk("t3_fwd_rs_e", fwd_rs_e, 0);
        flush();

        // lw $6 (tnew 2) ; sw $6 (tuse 2): no stall, store data from W in M
        set_d(0, 0, 0, 0, 0, 0, 6, 2, 0, 0, 0);
        cyc();
        set_d(0, 6, 0, 1, 0, 2, 0, 0, 0, 0, 0);
        #1 chk("t3b_nostall", stall, 0);
        cyc();
        nop();
        #1 chk("t3b_fwd_rt_e", fwd_rt_e, 0);
        cyc();
        #1 chk("t3b_fwd_rt_m", fwd_rt_m, 2);
        flush();

        // write to $0 then read $0: never a hazard
        set_d(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
        cyc();
        set_d(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_stall", stall, 0);
        chk("t4_fwd_rs_d", fwd_rs_d, 0);
        chk("t4_fwd_rt_d", fwd_rt_d, 0);
        cyc();
        nop();
        cyc();
        #1 chk("t4_fwd_rs_e", fwd_rs_e, 0);
        chk("t4_fwd_rt_m", fwd_rt_m, 0);
        flush();

        // div ; mflo: stall while div in E plus DIV_CYCLES busy cycles
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1 chk("t5_div_nostall", stall, 0);
        cyc();
        set_d(0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 1);
        sc = 0;
        bc = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (!stall) break;
            sc++;
            if (md_busy) bc++;
            @(posedge clk);
        end
        chk("t5_stall_cycles", sc, 11);
        chk("t5_busy_cycles", bc, 10);
        chk("t5_busy_after", md_busy, 0);
        flush();

        // mult, reset while counter is 3
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc();
        set_d(0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0);
        cyc();
        nop();
        cyc();
        cyc();
        set_d(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("t6_busy", md_busy, 1);
        chk("t6_stall", stall, 1);
        chk("t6_fwd_rs_d", fwd_rs_d, 2);
        rst_n = 1'b0;
        #1 chk("t6_rst_busy", md_busy, 0);
        chk("t6_rst_stall", stall, 0);
        chk("t6_rst_fwd_rs_d", fwd_rs_d, 0);
        nop();
        #1 chk_all_zero("t6_rst");
        cyc();
        rst_n = 1'b1;
        cyc();
        #1 chk("t6_post_busy", md_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
